// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 pulse generator.
//   state_t        per-channel FSM state encoding (IDLE / PULSE / HOLD)
//   cnt_w()        width of the per-channel pulse/hold-off down-counter
//   MAX_SYNC_STAGES  deepest supported input synchroniser
//   `HUB75_PARAM_CHECK(label, cond, msg)  elaboration-time parameter guard
`ifndef HUB75_PKG_SV
`define HUB75_PKG_SV

`define HUB75_PARAM_CHECK(lbl, cond, msg) \
    if (!(cond)) begin : lbl \
        $error(msg); \
    end

package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int MAX_SYNC_STAGES = 3;

    // Counter must hold PULSE_W-1 and HOLDOFF-1 without wrapping.
    function automatic int cnt_w(input int pulse_w, input int holdoff);
        int m;
        m = (pulse_w > holdoff) ? pulse_w : holdoff;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`endif

// File: rtl/hub75_pulse_gen_if.sv
// hub75_pulse_gen_if: request/status bundle of the HUB75 pulse generator.
//   en, clr_overrun   global controls (master -> slave)
//   req[NUM_CH]       per-channel requests (master -> slave)
//   pulse/busy/overrun[NUM_CH]  per-channel status (slave -> master)
interface hub75_pulse_gen_if #(
    parameter int NUM_CH = 1
);
    logic              en;
    logic [NUM_CH-1:0] req;
    logic              clr_overrun;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] overrun;

    modport master (
        output en, req, clr_overrun,
        input  pulse, busy, overrun
    );

    modport slave (
        input  en, req, clr_overrun,
        output pulse, busy, overrun
    );
endinterface

// File: rtl/hub75_pulse_chan.sv
// hub75_pulse_chan: one pulse-generator channel.
//   clk, rst      clock, asynchronous active-low reset
//   en            global enable (blocks new triggers, drops queued request)
//   req           request input (level or rising edge per EDGE_MODE)
//   clr_overrun   clears the overrun sticky bit
//   pulse         registered output pulse, PULSE_W cycles wide
//   busy          registered, high while in PULSE or HOLD
//   overrun       sticky, a request was dropped because one was already queued
module hub75_pulse_chan
    import hub75_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int EDGE_MODE   = 0,
    parameter int PULSE_W     = 1,
    parameter int HOLDOFF     = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req,
    input  logic clr_overrun,
    output logic pulse,
    output logic busy,
    output logic overrun
);
    localparam int CNT_W = cnt_w(PULSE_W, HOLDOFF);
    localparam logic [CNT_W-1:0] PW_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] HO_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    logic s;
    logic trig;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = req;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= req;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    if (EDGE_MODE != 0) begin : g_edge
        logic s_d;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) s_d <= 1'b0;
            else      s_d <= s;
        end
        assign trig = s & ~s_d & en;
    end else begin : g_level
        assign trig = s & en;
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pending, pend_nx, pend_now, ovr_set;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ovr_set  = 1'b0;
        // A queued request survives only while enabled (edge mode only).
        pend_now = (EDGE_MODE != 0) && pending && en;
        // A trigger arriving while active is queued before the transition is
        // decided, so a request landing on the last active cycle chains
        // straight into the next pulse instead of being lost.
        if ((EDGE_MODE != 0) && trig && (state != IDLE)) begin
            if (pend_now) ovr_set  = 1'b1;
            else          pend_now = 1'b1;
        end
        case (state)
            IDLE: begin
                pend_now = 1'b0;
                if (trig) begin
                    state_nx = PULSE;
                    cnt_nx   = PW_LOAD;
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (HOLDOFF > 0) begin
                    state_nx = HOLD;
                    cnt_nx   = HO_LOAD;
                end else if (pend_now) begin
                    cnt_nx   = PW_LOAD;
                    pend_now = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (pend_now) begin
                    state_nx = PULSE;
                    cnt_nx   = PW_LOAD;
                    pend_now = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                pend_now = 1'b0;
            end
        endcase
        pend_nx = pend_now;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            pulse   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= pend_nx;
            pulse   <= (state_nx == PULSE);
            busy    <= (state_nx != IDLE);
            // A new overrun outranks a simultaneous clear.
            if (ovr_set)          overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end
endmodule

// File: rtl/hub75_pulse_gen.sv
// hub75_pulse_gen: multi-channel HUB75 latch/blank/row pulse generator.
//   clk, rst   clock, asynchronous active-low reset
//   bus        hub75_pulse_gen_if.slave: en, req[], clr_overrun in;
//              pulse[], busy[], overrun[] out
// Each channel is an independent hub75_pulse_chan; en and clr_overrun are shared.
module hub75_pulse_gen
    import hub75_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int SYNC_STAGES = 0,
    parameter int EDGE_MODE   = 0,
    parameter int PULSE_W     = 1,
    parameter int HOLDOFF     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    hub75_pulse_gen_if.slave     bus
);
    `HUB75_PARAM_CHECK(g_bad_params,
        (NUM_CH >= 1) && (SYNC_STAGES >= 0) && (SYNC_STAGES <= MAX_SYNC_STAGES) &&
        ((EDGE_MODE == 0) || (EDGE_MODE == 1)) && (PULSE_W >= 1) && (HOLDOFF >= 0),
        "hub75_pulse_gen: illegal parameter value")

    logic [NUM_CH-1:0] pulse_v;
    logic [NUM_CH-1:0] busy_v;
    logic [NUM_CH-1:0] ovr_v;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hub75_pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE),
            .PULSE_W     (PULSE_W),
            .HOLDOFF     (HOLDOFF)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .en          (bus.en),
            .req         (bus.req[g]),
            .clr_overrun (bus.clr_overrun),
            .pulse       (pulse_v[g]),
            .busy        (busy_v[g]),
            .overrun     (ovr_v[g])
        );
    end

    assign bus.pulse   = pulse_v;
    assign bus.busy    = busy_v;
    assign bus.overrun = ovr_v;
endmodule

// File: tb/tb_hub75_pulse_gen.sv
module tb_hub75_pulse_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hub75_pulse_gen_if #(.NUM_CH(1)) if_leg();
    hub75_pulse_gen_if #(.NUM_CH(1)) if_edge();
    hub75_pulse_gen_if #(.NUM_CH(1)) if_sync();
    hub75_pulse_gen_if #(.NUM_CH(4)) if_multi();

    hub75_pulse_gen #(.NUM_CH(1), .SYNC_STAGES(0), .EDGE_MODE(0), .PULSE_W(1), .HOLDOFF(0))
        u_leg (.clk(clk), .rst(rst), .bus(if_leg));
    hub75_pulse_gen #(.NUM_CH(1), .SYNC_STAGES(0), .EDGE_MODE(1), .PULSE_W(3), .HOLDOFF(2))
        u_edge (.clk(clk), .rst(rst), .bus(if_edge));
    hub75_pulse_gen #(.NUM_CH(1), .SYNC_STAGES(2), .EDGE_MODE(1), .PULSE_W(1), .HOLDOFF(0))
        u_sync (.clk(clk), .rst(rst), .bus(if_sync));
    hub75_pulse_gen #(.NUM_CH(4), .SYNC_STAGES(0), .EDGE_MODE(1), .PULSE_W(3), .HOLDOFF(2))
        u_multi (.clk(clk), .rst(rst), .bus(if_multi));

    // Cycle t begins 1 time unit after the t-th rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if ({if_leg.pulse, if_leg.busy, if_leg.overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_leg got=%b exp=000", {if_leg.pulse, if_leg.busy, if_leg.overrun}); end
        checks++; if ({if_edge.pulse, if_edge.busy, if_edge.overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_edge got=%b exp=000", {if_edge.pulse, if_edge.busy, if_edge.overrun}); end
        checks++; if ({if_sync.pulse, if_sync.busy, if_sync.overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_sync got=%b exp=000", {if_sync.pulse, if_sync.busy, if_sync.overrun}); end
        checks++; if ({if_multi.pulse, if_multi.busy, if_multi.overrun} !== 12'h000) begin
            errors++; $display("FAIL reset_multi got=%h exp=000", {if_multi.pulse, if_multi.busy, if_multi.overrun}); end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_legacy();
        logic [0:6] ep;
        ep = 7'b0101010;
        for (int t = 0; t <= 6; t++) begin
            if_leg.req = (t <= 5) ? 1'b1 : 1'b0;
            checks++; if (if_leg.pulse !== ep[t]) begin
                errors++; $display("FAIL legacy_pulse t=%0d got=%b exp=%b", t, if_leg.pulse, ep[t]); end
            checks++; if (if_leg.busy !== ep[t]) begin
                errors++; $display("FAIL legacy_busy t=%0d got=%b exp=%b", t, if_leg.busy, ep[t]); end
            tick();
        end
        if_leg.req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_edge_single();
        logic [0:8] ep, eb;
        ep = 9'b011100000;
        eb = 9'b011111000;
        for (int t = 0; t <= 8; t++) begin
            if_edge.req = (t == 0) ? 1'b1 : 1'b0;
            checks++; if (if_edge.pulse !== ep[t]) begin
                errors++; $display("FAIL single_pulse t=%0d got=%b exp=%b", t, if_edge.pulse, ep[t]); end
            checks++; if (if_edge.busy !== eb[t]) begin
                errors++; $display("FAIL single_busy t=%0d got=%b exp=%b", t, if_edge.busy, eb[t]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [0:11] ep, eb;
        ep = 12'b011100111000;
        eb = 12'b011111111110;
        for (int t = 0; t <= 11; t++) begin
            if_edge.req = (t == 0 || t == 2) ? 1'b1 : 1'b0;
            checks++; if (if_edge.pulse !== ep[t]) begin
                errors++; $display("FAIL b2b_pulse t=%0d got=%b exp=%b", t, if_edge.pulse, ep[t]); end
            checks++; if (if_edge.busy !== eb[t]) begin
                errors++; $display("FAIL b2b_busy t=%0d got=%b exp=%b", t, if_edge.busy, eb[t]); end
            checks++; if (if_edge.overrun !== 1'b0) begin
                errors++; $display("FAIL b2b_overrun t=%0d got=%b exp=0", t, if_edge.overrun); end
            tick();
        end
    endtask

    task automatic test_overrun();
        logic [0:11] ep, eo;
        ep = 12'b011100111000;
        eo = 12'b000001111111;
        for (int t = 0; t <= 11; t++) begin
            if_edge.req = (t == 0 || t == 2 || t == 4) ? 1'b1 : 1'b0;
            checks++; if (if_edge.pulse !== ep[t]) begin
                errors++; $display("FAIL ovr_pulse t=%0d got=%b exp=%b", t, if_edge.pulse, ep[t]); end
            checks++; if (if_edge.overrun !== eo[t]) begin
                errors++; $display("FAIL ovr_flag t=%0d got=%b exp=%b", t, if_edge.overrun, eo[t]); end
            tick();
        end
        if_edge.clr_overrun = 1'b1;
        tick();
        if_edge.clr_overrun = 1'b0;
        checks++; if (if_edge.overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clear got=%b exp=0", if_edge.overrun); end
        // Clear asserted in the same cycle as a new overrun: the set must win.
        for (int t = 0; t <= 11; t++) begin
            if_edge.req = (t == 0 || t == 2 || t == 4) ? 1'b1 : 1'b0;
            if_edge.clr_overrun = (t == 4) ? 1'b1 : 1'b0;
            checks++; if (if_edge.overrun !== eo[t]) begin
                errors++; $display("FAIL ovr_setwins t=%0d got=%b exp=%b", t, if_edge.overrun, eo[t]); end
            tick();
        end
        if_edge.clr_overrun = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        for (int t = 0; t <= 2; t++) begin
            if_edge.req = (t == 0) ? 1'b1 : 1'b0;
            if (t == 0) begin
                checks++; if (if_edge.overrun !== 1'b1) begin
                    errors++; $display("FAIL rstmid_ovr_before got=%b exp=1", if_edge.overrun); end
            end
            if (t >= 1) begin
                checks++; if (if_edge.pulse !== 1'b1) begin
                    errors++; $display("FAIL rstmid_pulse_before t=%0d got=%b exp=1", t, if_edge.pulse); end
            end
            if (t < 2) tick();
        end
        rst = 1'b0;
        #1;
        checks++; if ({if_edge.pulse, if_edge.busy, if_edge.overrun} !== 3'b000) begin
            errors++; $display("FAIL rstmid_async got=%b exp=000", {if_edge.pulse, if_edge.busy, if_edge.overrun}); end
        repeat (2) tick();
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++; if ({if_edge.pulse, if_edge.busy} !== 2'b00) begin
                errors++; $display("FAIL rstmid_after t=%0d got=%b exp=00", t, {if_edge.pulse, if_edge.busy}); end
        end
    endtask

    task automatic test_sync();
        logic [0:7] ep;
        ep = 8'b00010000;
        for (int t = 0; t <= 7; t++) begin
            if_sync.req = (t <= 3) ? 1'b1 : 1'b0;
            checks++; if (if_sync.pulse !== ep[t]) begin
                errors++; $display("FAIL sync_pulse t=%0d got=%b exp=%b", t, if_sync.pulse, ep[t]); end
            checks++; if (if_sync.busy !== ep[t]) begin
                errors++; $display("FAIL sync_busy t=%0d got=%b exp=%b", t, if_sync.busy, ep[t]); end
            tick();
        end
    endtask

    task automatic test_multi();
        logic [3:0] ep, eb, eo;
        for (int t = 0; t <= 11; t++) begin
            if_multi.req = {(t == 0), 2'b00, (t == 0 || t == 2 || t == 4)};
            ep = {((t >= 1) && (t <= 3)), 2'b00, ((t >= 1 && t <= 3) || (t >= 6 && t <= 8))};
            eb = {((t >= 1) && (t <= 5)), 2'b00, ((t >= 1) && (t <= 10))};
            eo = {3'b000, (t >= 5)};
            checks++; if (if_multi.pulse !== ep) begin
                errors++; $display("FAIL multi_pulse t=%0d got=%b exp=%b", t, if_multi.pulse, ep); end
            checks++; if (if_multi.busy !== eb) begin
                errors++; $display("FAIL multi_busy t=%0d got=%b exp=%b", t, if_multi.busy, eb); end
            checks++; if (if_multi.overrun !== eo) begin
                errors++; $display("FAIL multi_ovr t=%0d got=%b exp=%b", t, if_multi.overrun, eo); end
            tick();
        end
        // Disabled batch: edges on every channel must be ignored.
        if_multi.en = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            if_multi.req = (t == 0) ? 4'b1111 : 4'b0000;
            checks++; if ({if_multi.pulse, if_multi.busy} !== 8'h00) begin
                errors++; $display("FAIL multi_en0 t=%0d got=%b exp=00000000", t, {if_multi.pulse, if_multi.busy}); end
            tick();
        end
        if_multi.en = 1'b1;
        checks++; if (if_multi.overrun !== 4'b0001) begin
            errors++; $display("FAIL multi_ovr_hold got=%b exp=0001", if_multi.overrun); end
        if_multi.clr_overrun = 1'b1;
        tick();
        if_multi.clr_overrun = 1'b0;
        checks++; if (if_multi.overrun !== 4'b0000) begin
            errors++; $display("FAIL multi_ovr_clear got=%b exp=0000", if_multi.overrun); end
    endtask

    initial begin
        if_leg.en = 1'b1;   if_leg.req = '0;   if_leg.clr_overrun = 1'b0;
        if_edge.en = 1'b1;  if_edge.req = '0;  if_edge.clr_overrun = 1'b0;
        if_sync.en = 1'b1;  if_sync.req = '0;  if_sync.clr_overrun = 1'b0;
        if_multi.en = 1'b1; if_multi.req = '0; if_multi.clr_overrun = 1'b0;
        test_reset();
        test_legacy();
        test_edge_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid_pulse();
        test_sync();
        test_multi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
